paa1_serial_ctrl: RTL and testbench

Multi-cycle controller that sequences the team's 2-bit no-carry-in approximate adder slice (PAA1) across a WIDTH-bit operand pair, two bits per cycle, LSB slice first. It latches operands on a start handshake, steps an internal slice index, assembles the result, and raises a one-cycle done pulse. Mode 0 reproduces the pure segmented approximate adder, with inter-slice carries dropped. Mode 1 adds each slice's carry into the next slice's result. It sits between an operand source and a result consumer in the approximate-arithmetic test datapath.

---
 rtl/paa1_serial_ctrl_if.sv | 16 +
 rtl/paa1_serial_ctrl.sv | 119 +++++++++++
 tb/tb_paa1_serial_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/paa1_serial_ctrl_if.sv
// Operand/result bundle between the operand source, paa1_serial_ctrl and the result consumer.
interface paa1_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             cout;

    modport master (output start, mode, in0, in1, input busy, done, out, cout);
    modport slave  (input start, mode, in0, in1, output busy, done, out, cout);
endinterface

// File: rtl/paa1_serial_ctrl.sv
// Sequences the 2-bit PAA1 approximate adder slice across a WIDTH-bit operand pair,
// one slice per cycle, LSB first; mode 1 folds each slice carry into the next slice result.
module paa1_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    paa1_serial_ctrl_if.slave  bus
);
    localparam int N  = WIDTH / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             mode_q, mode_d;
    logic             cp_q, cp_d;
    logic             cout_q, cout_d;
    logic             busy_q, done_q;

    logic [1:0] sa, sb;
    logic       s0, s1, sc;
    logic [2:0] corr;

    // PAA1 slice on the current operand pair; corr is the carry-forward corrected sum.
    always_comb begin
        sa   = a_q[2*k_q +: 2];
        sb   = b_q[2*k_q +: 2];
        s0   = sa[0] ^ sb[0];
        s1   = (sa[1] ^ sb[1]) ^ (sa[0] & sb[0]);
        sc   = (sa[0] & sb[0]) | (sa[1] & sb[1]);
        corr = {1'b0, s1, s0} + {2'b00, cp_q};
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        cp_d    = cp_q;
        out_d   = out_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.in0;
                    b_d     = bus.in1;
                    mode_d  = bus.mode;
                    k_d     = '0;
                    out_d   = '0;
                    cp_d    = 1'b0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (mode_q) begin
                    out_d[2*k_q +: 2] = corr[1:0];
                    cp_d              = sc | corr[2];
                end else begin
                    out_d[2*k_q +: 2] = {s1, s0};
                    cp_d              = sc;
                end
                if (k_q == KW'(N - 1)) begin
                    cout_d  = cp_d;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            cp_q    <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            cp_q    <= cp_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_paa1_serial_ctrl.sv
// Self-checking bench for paa1_serial_ctrl: directed corner cases, handshake behaviour,
// mid-run reset and randomized operands against an arithmetic reference model.
module tb_paa1_serial_ctrl;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    paa1_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();
    paa1_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: slice sum bits are the low two bits of the 2-bit add, slice carry is any
    // bit position where both operands are 1; mode 1 adds the running carry to each slice.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic m);
        int av, bv, sa, sb, c, t, cp, r;
        av = int'(a);
        bv = int'(b);
        cp = 0;
        r  = 0;
        for (int k = 0; k < N; k++) begin
            sa = (av >> (2 * k)) & 3;
            sb = (bv >> (2 * k)) & 3;
            c  = ((sa & sb) != 0) ? 1 : 0;
            t  = (sa + sb) & 3;
            if (m) begin
                t  = t + cp;
                cp = c | (t >> 2);
            end else begin
                cp = c;
            end
            r = r | ((t & 3) << (2 * k));
        end
        return {cp[0], r[WIDTH-1:0]};
    endfunction

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic m);
        logic [WIDTH:0] exp;
        int edges, busy_cnt;
        exp      = model(a, b, m);
        edges    = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in0   = a;
        bus.in1   = b;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (bus.busy) busy_cnt++;
        while (!bus.done && edges < 4 * N + 4) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.busy) busy_cnt++;
        end
        check({tag, " latency"}, edges, N);
        check({tag, " busy_cycles"}, busy_cnt, N);
        check({tag, " out"}, bus.out, exp[WIDTH-1:0]);
        check({tag, " cout"}, bus.cout, exp[WIDTH]);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, bus.done, 1'b0);
        check({tag, " out_hold"}, bus.out, exp[WIDTH-1:0]);
    endtask

    initial begin
        logic [WIDTH:0]   exp1, exp2;
        logic [WIDTH-1:0] ra, rb, ra2, rb2;
        logic             rm, rm2;
        int               done_cnt, busy_cnt, first_done, second_done;
        logic [WIDTH-1:0] first_out, second_out;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.in0   = '0;
        bus.in1   = '0;
        #12;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset out", bus.out, '0);
        check("reset cout", bus.cout, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op("m0 01+01", 8'h01, 8'h01, 1'b0);
        check("model 01+01", model(8'h01, 8'h01, 1'b0), 9'h002);
        run_op("m0 03+01", 8'h03, 8'h01, 1'b0);
        run_op("m1 03+01", 8'h03, 8'h01, 1'b1);
        check("model m1 03+01", model(8'h03, 8'h01, 1'b1), 9'h004);
        run_op("m0 FF+FF", 8'hFF, 8'hFF, 1'b0);
        check("model m0 FF+FF", model(8'hFF, 8'hFF, 1'b0), 9'h1AA);
        run_op("m1 FF+FF", 8'hFF, 8'hFF, 1'b1);
        check("model m1 FF+FF", model(8'hFF, 8'hFF, 1'b1), 9'h1FE);

        // Start pulsed during every RUN cycle with a changed operand must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in0   = 8'h01;
        bus.in1   = 8'h01;
        bus.mode  = 1'b0;
        @(posedge clk);
        #1;
        done_cnt = 0;
        busy_cnt = bus.busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = (i < N) ? 1'b1 : 1'b0;
            bus.in0   = 8'hFF;
            @(posedge clk);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                check("ignore out", bus.out, 8'h02);
            end
        end
        bus.start = 1'b0;
        check("ignore done_count", done_cnt, 1);
        check("ignore busy_cycles", busy_cnt, N);

        // Start held high: second operand set accepted in the DONE cycle.
        ra   = 8'($urandom);
        rb   = 8'($urandom);
        rm   = 1'($urandom);
        ra2  = 8'($urandom);
        rb2  = 8'($urandom);
        rm2  = 1'($urandom);
        exp1 = model(ra, rb, rm);
        exp2 = model(ra2, rb2, rm2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in0   = ra;
        bus.in1   = rb;
        bus.mode  = rm;
        @(posedge clk);
        #1;
        first_done  = -1;
        second_done = -1;
        first_out   = '0;
        second_out  = '0;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            bus.start = (e <= N + 1) ? 1'b1 : 1'b0;
            bus.in0   = ra2;
            bus.in1   = rb2;
            bus.mode  = rm2;
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (first_done < 0) begin
                    first_done = e;
                    first_out  = bus.out;
                end else if (second_done < 0) begin
                    second_done = e;
                    second_out  = bus.out;
                    check("b2b second cout", bus.cout, exp2[WIDTH]);
                end
            end
        end
        bus.start = 1'b0;
        check("b2b first done edge", first_done, N);
        check("b2b first out", first_out, exp1[WIDTH-1:0]);
        check("b2b done spacing", second_done - first_done, N + 1);
        check("b2b second out", second_out, exp2[WIDTH-1:0]);

        // Asynchronous reset in the middle of RUN at slice index 2.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in0   = 8'h5A;
        bus.in1   = 8'h33;
        bus.mode  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midrst busy before", bus.busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy", bus.busy, 1'b0);
        check("midrst done", bus.done, 1'b0);
        check("midrst out", bus.out, '0);
        check("midrst cout", bus.cout, 1'b0);
        rst      = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        check("midrst no done", done_cnt, 0);
        check("midrst no busy", busy_cnt, 0);
        run_op("after rst", 8'h5A, 8'h33, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
